branch_flag_resolve: RTL and testbench
======================================

# branch_flag_resolve

- Sits in the EX stage of the 5-stage pipeline and is the consumer of the ALU's 64-bit zero detection.
- Holds the architectural condition flags N, Z, C, V, written by flag-setting ALU instructions.
- Resolves unconditional, CBZ, CBNZ and B.cond branches and drives a registered taken/flush pulse to fetch and decode.
- Runs a one-cycle wrong-path shadow after each taken branch and keeps a saturating taken-branch counter for performance debug.

## Interface
Parameters:
- WIDTH, 64, datapath width of ALU result and CBZ operand
- CNT_W, 32, width of taken-branch counter

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state while 0
- stall  in  1  pipeline hold; all state frozen when 1
- flag_we  in  1  current EX instruction sets flags
- alu_result  in  WIDTH  ALU result of current EX instruction
- alu_carry  in  1  ALU carry-out
- alu_overflow  in  1  ALU signed overflow
- br_valid  in  1  current EX instruction is a branch
- br_kind  in  2  0 B, 1 CBZ, 2 B.cond, 3 CBNZ
- cond  in  4  B.cond code: 0 EQ, 1 NE, 2 HS, 3 LO, 4 MI, 5 PL, 6 VS, 7 VC, 8 HI, 9 LS, A GE, B LT, C GT, D LE, E/F always
- cbz_operand  in  WIDTH  register value tested by CBZ/CBNZ
- flag_n, flag_z, flag_c, flag_v  out  1 each  registered architectural flags
- br_taken  out  1  registered one-cycle pulse, branch taken
- flush  out  1  registered one-cycle pulse, squash IF/ID
- taken_count  out  CNT_W  saturating count of taken branches

## Operation
- Reset (reset=0, asynchronous): all flags, br_taken, flush and taken_count are 0; FSM goes to IDLE.
- Effective flags for the current cycle:
  - If flag_we=1: N=alu_result[WIDTH-1], Z=~|alu_result, C=alu_carry, V=alu_overflow. This same-cycle bypass feeds B.cond.
  - Otherwise: the registered flags.
- Branch condition:
  - B: always taken.
  - CBZ: taken iff cbz_operand==0. CBNZ: taken iff cbz_operand!=0.
  - B.cond uses the standard ARM semantics:
    - HS = C; HI = C&~Z; LS = ~C|Z
    - GE = N==V; LT = N!=V
    - GT = ~Z&(N==V); LE = Z|(N!=V)
- FSM states:
  - IDLE:
    - Inputs are accepted.
    - A taken branch with stall=0 moves to SHADOW.
  - SHADOW:
    - flag_we and br_valid are ignored; this is the wrong-path instruction.
    - Moves to IDLE on the first cycle with stall=0.
    - Stays in SHADOW while stall=1.
- Flag register:
  - Loads the effective flags at the clock edge when flag_we=1, stall=0 and state=IDLE.
  - Holds otherwise.
- taken_count:
  - Increments on each accepted taken branch.
  - Saturates at all-ones and does not wrap.
- An instruction that both sets flags and is a branch is legal. Flags update and the branch resolves in the same cycle, and B.cond sees the new flags.

## Timing
- Branch presented in cycle N with IDLE and stall=0, taken:
  - br_taken=1 and flush=1 during cycle N+1 only.
  - Both return to 0 in N+2, even if stall=1 in N+1.
- Not-taken branch: br_taken and flush stay 0.
- stall=1 in IDLE: the branch is not resolved. It is re-presented when stall drops, and br_taken/flush stay 0 during the stall.
- Flags written in cycle N are visible on flag_* in N+1. A B.cond in N+1 reads the registered value.
- Back-to-back taken branches:
  - The second arrives in SHADOW and is ignored.
  - No second pulse; taken_count increments once.
- Reset mid-pulse: br_taken and flush drop to 0 immediately (asynchronous). The state after release is IDLE.
- Combinational path: inputs to the next-state logic only. No combinational input-to-output path.

## Test plan
- Reset then release, idle:
  - All outputs are 0.
  - CBZ with cbz_operand=0 in cycle 5 gives br_taken=flush=1 in cycle 6, 0 in cycle 7, and taken_count=1.
- Flag write:
  - flag_we=1, alu_result=64'h0, carry=1, overflow=0, then next cycle N,Z,C,V=0,1,1,0.
  - alu_result=64'h8000000000000000 gives N,Z=1,0.
- Bypass:
  - Same cycle flag_we=1 with alu_result=0 and B.cond EQ is taken.
  - With alu_result=1 it is not taken, even though the stale Z=1.
- Shadow:
  - B at cycle 3, then CBNZ with cbz_operand=5 and flag_we=1 at cycle 4.
  - Single pulse at cycle 4, flags unchanged, taken_count=1.
- Stall:
  - B.cond GE with N=V=1 is held by stall=1 for 3 cycles: no pulse.
  - The pulse comes one cycle after stall drops.
- Saturation / reset:
  - Preload taken_count near max with CNT_W=4 and take 20 branches: it holds at 4'hF.
  - Assert reset during the pulse: outputs go to 0 asynchronously.

Source files
------------

// File: rtl/branch_flag_resolve.sv
// branch_flag_resolve: EX-stage NZCV flag register, branch resolver, wrong-path shadow and taken counter
module branch_flag_resolve #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flag_we,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   input  logic             alu_overflow,
   input  logic             br_valid,
   input  logic [1:0]       br_kind,
   input  logic [3:0]       cond,
   input  logic [WIDTH-1:0] cbz_operand,
   output logic             flag_n,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_v,
   output logic             br_taken,
   output logic             flush,
   output logic [CNT_W-1:0] taken_count
);
   typedef enum logic {IDLE, SHADOW} state_t;
   state_t state, state_nx;
   logic en, ez, ec, ev, cond_base, cond_ok, taken, accept, take;

   // effective flags (same-cycle bypass) and branch condition
   always_comb begin
      en = flag_we ? alu_result[WIDTH-1] : flag_n;
      ez = flag_we ? ~|alu_result : flag_z;
      ec = flag_we ? alu_carry : flag_c;
      ev = flag_we ? alu_overflow : flag_v;
      case (cond[3:1])
         3'd0:    cond_base = ez;
         3'd1:    cond_base = ec;
         3'd2:    cond_base = en;
         3'd3:    cond_base = ev;
         3'd4:    cond_base = ec & ~ez;
         3'd5:    cond_base = en == ev;
         3'd6:    cond_base = ~ez & (en == ev);
         default: cond_base = 1'b1;
      endcase
      cond_ok = cond_base ^ (cond[0] & ~&cond[3:1]);
      taken = (br_kind == 2'd0) ? 1'b1 :
              (br_kind == 2'd1) ? ~|cbz_operand :
              (br_kind == 2'd3) ? |cbz_operand : cond_ok;
   end

   // FSM output: instruction is accepted only in IDLE without stall
   always_comb begin
      accept = (state == IDLE) & ~stall;
      take = accept & br_valid & taken;
   end

   // FSM next state: a taken branch opens one wrong-path shadow slot
   always_comb begin
      state_nx = (state == IDLE) ? (take ? SHADOW : IDLE) : (stall ? SHADOW : IDLE);
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // taken pulse is one cycle wide regardless of stall
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) br_taken <= 1'b0;
      else        br_taken <= take;
   end

   assign flush = br_taken;

   // architectural flags load only from accepted flag-setting instructions
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                {flag_n, flag_z, flag_c, flag_v} <= '0;
      else if (accept & flag_we) {flag_n, flag_z, flag_c, flag_v} <= {en, ez, ec, ev};
   end

   // saturating taken-branch counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                    taken_count <= '0;
      else if (take & ~&taken_count) taken_count <= taken_count + 1'b1;
   end
endmodule

// File: tb/tb_branch_flag_resolve.sv
// tb_branch_flag_resolve: scoreboard bench with a behavioural reference model
module tb_branch_flag_resolve;
   logic        clk = 0;
   logic        reset = 0;
   logic        stall = 0, flag_we = 0, alu_carry = 0, alu_overflow = 0, br_valid = 0;
   logic [63:0] alu_result = '0, cbz_operand = '0;
   logic [1:0]  br_kind = '0;
   logic [3:0]  cond = '0;
   logic        flag_n, flag_z, flag_c, flag_v, br_taken, flush;
   logic [3:0]  taken_count;

   int errors = 0, checks = 0;
   logic [9:0] exp_q[$];
   logic [9:0] e;

   bit m_n, m_z, m_c, m_v, m_shadow;
   int m_cnt;

   branch_flag_resolve #(.WIDTH(64), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flag_we(flag_we),
      .alu_result(alu_result), .alu_carry(alu_carry), .alu_overflow(alu_overflow),
      .br_valid(br_valid), .br_kind(br_kind), .cond(cond), .cbz_operand(cbz_operand),
      .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
      .br_taken(br_taken), .flush(flush), .taken_count(taken_count)
   );

   always #5 clk = ~clk;

   wire [9:0] act = {flag_n, flag_z, flag_c, flag_v, br_taken, flush, taken_count};

   function automatic bit arm_cond(input logic [3:0] c, input bit n, z, cc, v);
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cc;
         4'h3: return !cc;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cc && !z;
         4'h9: return !cc || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && n == v;
         4'hD: return z || n != v;
         default: return 1;
      endcase
   endfunction

   task automatic chk(input string name, input logic [9:0] a, input logic [9:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s got=%b want=%b", name, a, x);
      end
   endtask

   // one cycle of stimulus; the model predicts the state after the next rising edge
   task automatic drive(input bit st, fw, input logic [63:0] ar, input bit ca, ov, bv,
                        input logic [1:0] bk, input logic [3:0] cd, input logic [63:0] op);
      bit n, z, c, v, ok, fire, acc;
      @(negedge clk);
      stall = st; flag_we = fw; alu_result = ar; alu_carry = ca; alu_overflow = ov;
      br_valid = bv; br_kind = bk; cond = cd; cbz_operand = op;
      acc = !m_shadow && !st;
      if (fw) begin n = ar[63]; z = (ar == 0); c = ca; v = ov; end
      else begin n = m_n; z = m_z; c = m_c; v = m_v; end
      case (bk)
         2'd0: ok = 1;
         2'd1: ok = (op == 0);
         2'd3: ok = (op != 0);
         default: ok = arm_cond(cd, n, z, c, v);
      endcase
      fire = acc && bv && ok;
      if (acc && fw) begin m_n = n; m_z = z; m_c = c; m_v = v; end
      if (fire && m_cnt < 15) m_cnt++;
      m_shadow = m_shadow ? st : fire;
      exp_q.push_back({m_n, m_z, m_c, m_v, fire, fire, 4'(m_cnt)});
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic model_reset();
      m_n = 0; m_z = 0; m_c = 0; m_v = 0; m_shadow = 0; m_cnt = 0;
   endtask

   // monitor: compares the DUT against the oldest prediction after each edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (act !== e) begin
            errors++;
            $display("FAIL cycle_out t=%0t got=%b want=%b (nzcv,br,flush,cnt)", $time, act, e);
         end
      end
   end

   initial begin
      logic [63:0] ar, op;
      model_reset();
      repeat (3) @(posedge clk);
      #2 chk("reset_hold", act, 10'b0);
      @(negedge clk) reset = 1;
      idle(4);
      drive(0, 0, 0, 0, 0, 1, 2'd1, 0, 64'h0);
      idle(2);
      drive(0, 1, 64'h0, 1, 0, 0, 0, 0, 0);
      idle(1);
      drive(0, 1, 64'h8000000000000000, 0, 0, 0, 0, 0, 0);
      idle(1);
      drive(0, 1, 64'h1, 1, 0, 0, 0, 0, 0);
      drive(0, 1, 64'h0, 0, 0, 1, 2'd2, 4'h0, 0);
      idle(1);
      drive(0, 1, 64'h1, 0, 0, 1, 2'd2, 4'h0, 0);
      idle(1);
      drive(0, 0, 0, 0, 0, 1, 2'd0, 0, 0);
      drive(0, 1, 64'h0, 1, 1, 1, 2'd3, 0, 64'd5);
      idle(2);
      drive(0, 1, 64'h8000000000000000, 0, 1, 0, 0, 0, 0);
      repeat (3) drive(1, 0, 0, 0, 0, 1, 2'd2, 4'hA, 0);
      drive(0, 0, 0, 0, 0, 1, 2'd2, 4'hA, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(2);
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 0, 0, 1, 2'd0, 0, 0);
         idle(1);
      end
      model_reset();
      @(negedge clk) reset = 0;
      @(negedge clk) reset = 1;
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 3))
            0: ar = 64'h0;
            1: ar = {1'b1, 31'($urandom), 32'($urandom)};
            default: ar = {32'($urandom), 32'($urandom)};
         endcase
         op = ($urandom_range(0, 2) == 0) ? 64'h0 : {32'($urandom), 32'($urandom)};
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, ar,
               1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), op);
      end
      idle(2);
      drive(0, 0, 0, 0, 0, 1, 2'd0, 0, 0);
      @(posedge clk);
      #3 reset = 0;
      #1 chk("reset_async", act, 10'b0);
      br_valid = 0;
      model_reset();
      @(negedge clk) reset = 1;
      idle(1);
      drive(0, 0, 0, 0, 0, 1, 2'd1, 0, 64'h0);
      idle(2);
      @(posedge clk);
      #3;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
